// File: rtl/data_mem_responder.sv
// Single-outstanding data memory responder for the CPU MEM stage.
// Big-endian byte storage with a fixed request-to-response latency.
module data_mem_responder #(
   parameter int unsigned DEPTH_BYTES = 128,
   parameter int unsigned LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [63:0] req_address,
   input  logic [63:0] req_wdata,
   input  logic [3:0]  req_size,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [63:0] resp_rdata,
   output logic        resp_error
);
   localparam int unsigned AW = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
   state_t state, state_next;

   logic [3:0]    cnt;
   logic          lat_write;
   logic [63:0]   lat_address;
   logic [63:0]   lat_wdata;
   logic [3:0]    lat_size;
   logic [7:0]    mem [DEPTH_BYTES];

   logic          accept;
   logic          finish;
   logic          size_ok;
   logic          misaligned;
   logic          out_of_range;
   logic          req_error;
   logic [AW-1:0] base;
   logic [63:0]   load_data;
   logic [7:0]    store_byte [8];

   assign req_ready  = (state == IDLE) && !rst;
   assign resp_valid = (state == RESP);
   assign accept     = req_valid && req_ready;
   assign finish     = (state == BUSY) && (cnt == '0);
   assign base       = lat_address[AW-1:0];

   // Range check is done in 65 bits so addresses near 2^64 cannot wrap into range.
   always_comb begin
      size_ok      = (lat_size == 4'd1) || (lat_size == 4'd2) ||
                     (lat_size == 4'd4) || (lat_size == 4'd8);
      misaligned   = (lat_address[3:0] & (lat_size - 4'd1)) != 4'd0;
      out_of_range = ({1'b0, lat_address} + {61'd0, lat_size}) > 65'(DEPTH_BYTES);
      req_error    = !size_ok || misaligned || out_of_range;
   end

   // Lowest address lands in the most significant byte of the group.
   always_comb begin
      load_data = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         store_byte[i] = '0;
         if (size_ok && (i < 32'(lat_size))) begin
            load_data     = {load_data[55:0], mem[base + AW'(i)]};
            store_byte[i] = 8'(lat_wdata >> (8 * (32'(lat_size) - 1 - i)));
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = BUSY;
         BUSY:    if (cnt == '0) state_next = RESP;
         RESP:    if (resp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         lat_write   <= req_write;
         lat_address <= req_address;
         lat_wdata   <= req_wdata;
         lat_size    <= req_size;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt        <= '0;
         resp_rdata <= '0;
         resp_error <= 1'b0;
      end else begin
         case (state)
            IDLE: if (accept) cnt <= 4'(LATENCY - 1);
            BUSY: begin
               if (cnt != '0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  resp_error <= req_error;
                  resp_rdata <= (req_error || lat_write) ? '0 : load_data;
               end
            end
            RESP: begin
               if (resp_ready) begin
                  resp_rdata <= '0;
                  resp_error <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && finish && lat_write && !req_error) begin
         for (int unsigned i = 0; i < 8; i++) begin
            if (i < 32'(lat_size)) mem[base + AW'(i)] <= store_byte[i];
         end
      end
   end
endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: three responders (LATENCY 2, 1, 5) against a byte-array reference model.
module tb_data_mem_responder;
   localparam int DEPTH = 128;
   localparam int NI    = 3;

   typedef struct {
      int          k;
      logic [63:0] rdata;
      logic        err;
      int          acc;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        req_valid   [NI];
   logic        req_ready   [NI];
   logic        req_write   [NI];
   logic [63:0] req_address [NI];
   logic [63:0] req_wdata   [NI];
   logic [3:0]  req_size    [NI];
   logic        resp_valid  [NI];
   logic        resp_ready  [NI];
   logic [63:0] resp_rdata  [NI];
   logic        resp_error  [NI];

   int          lats [NI] = '{2, 1, 5};
   logic [7:0]  mm [NI][DEPTH];
   exp_t        sbq [$];
   exp_t        cur [NI];
   bit          have_cur [NI];
   bit          prev_v [NI];
   int          cyc;
   int          n_checks;
   int          n_fail;

   data_mem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(2)) dut_l2 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
      .req_address(req_address[0]), .req_wdata(req_wdata[0]), .req_size(req_size[0]),
      .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
      .resp_rdata(resp_rdata[0]), .resp_error(resp_error[0]));

   data_mem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(1)) dut_l1 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
      .req_address(req_address[1]), .req_wdata(req_wdata[1]), .req_size(req_size[1]),
      .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
      .resp_rdata(resp_rdata[1]), .resp_error(resp_error[1]));

   data_mem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(5)) dut_l5 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_write(req_write[2]),
      .req_address(req_address[2]), .req_wdata(req_wdata[2]), .req_size(req_size[2]),
      .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]),
      .resp_rdata(resp_rdata[2]), .resp_error(resp_error[2]));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: bound expired", name);
   endtask

   // Reference: memory is a plain byte array; a size-byte value is sum(byte_i << 8*(size-1-i)).
   function automatic void model(input int k, input bit w, input logic [63:0] a,
                                 input logic [63:0] d, input int s,
                                 output logic [63:0] rd, output logic er);
      rd = '0;
      er = !(s == 1 || s == 2 || s == 4 || s == 8);
      if (!er) er = ((a % 64'(s)) != 0) || (a > 64'(DEPTH - s));
      if (er) return;
      for (int i = 0; i < s; i++) begin
         if (w) mm[k][a + 64'(i)] = 8'(d >> (8 * (s - 1 - i)));
         else   rd = rd | (64'(mm[k][a + 64'(i)]) << (8 * (s - 1 - i)));
      end
   endfunction

   // Monitor: pops the expectation when resp_valid rises, then checks every valid cycle.
   always @(negedge clk) begin
      for (int k = 0; k < NI; k++) begin
         if (rst) begin
            prev_v[k] = 1'b0;
         end else if (resp_valid[k]) begin
            if (!prev_v[k]) begin
               if (sbq.size() == 0) begin
                  have_cur[k] = 1'b0;
                  fail_now($sformatf("unexpected_resp[%0d]", k));
               end else begin
                  cur[k]      = sbq.pop_front();
                  have_cur[k] = 1'b1;
                  chk($sformatf("resp_instance[%0d]", k), 64'(k), 64'(cur[k].k));
                  chk($sformatf("latency[%0d]", k), 64'(cyc - cur[k].acc), 64'(lats[k]));
               end
            end
            if (have_cur[k]) begin
               chk($sformatf("resp_rdata[%0d]", k), resp_rdata[k], cur[k].rdata);
               chk($sformatf("resp_error[%0d]", k), 64'(resp_error[k]), 64'(cur[k].err));
            end
            prev_v[k] = 1'b1;
         end else begin
            prev_v[k] = 1'b0;
         end
      end
   end

   task automatic xfer(input int k, input bit w, input logic [63:0] a, input logic [63:0] d,
                       input int s, input int hold, input bit fixed,
                       input logic [63:0] frd, input logic ferr);
      exp_t        e;
      int          n;
      logic [63:0] mrd;
      logic        mer;
      @(negedge clk);
      req_valid[k]   = 1'b1;
      req_write[k]   = w;
      req_address[k] = a;
      req_wdata[k]   = d;
      req_size[k]    = 4'(s);
      n = 0;
      while (!req_ready[k] && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready[k]) begin
         req_valid[k] = 1'b0;
         fail_now($sformatf("accept_timeout[%0d]", k));
         return;
      end
      @(posedge clk);
      #1;
      model(k, w, a, d, s, mrd, mer);
      e.k     = k;
      e.rdata = fixed ? frd : mrd;
      e.err   = fixed ? ferr : mer;
      e.acc   = cyc;
      sbq.push_back(e);
      req_valid[k] = 1'b0;
      @(negedge clk);
      n = 0;
      while (!resp_valid[k] && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!resp_valid[k]) begin
         fail_now($sformatf("resp_timeout[%0d]", k));
         return;
      end
      // A competing store is offered while the response is stalled; it must be ignored.
      for (int i = 0; i < hold; i++) begin
         req_valid[k]   = 1'b1;
         req_write[k]   = 1'b1;
         req_address[k] = '0;
         req_wdata[k]   = {$urandom, $urandom};
         req_size[k]    = 4'd8;
         @(negedge clk);
         chk($sformatf("req_ready_stall[%0d]", k), 64'(req_ready[k]), 64'd0);
      end
      req_valid[k]  = 1'b0;
      resp_ready[k] = 1'b1;
      @(negedge clk);
      resp_ready[k] = 1'b0;
      chk($sformatf("valid_clear[%0d]", k), 64'(resp_valid[k]), 64'd0);
      chk($sformatf("rdata_clear[%0d]", k), resp_rdata[k], 64'd0);
      chk($sformatf("error_clear[%0d]", k), 64'(resp_error[k]), 64'd0);
      chk($sformatf("req_ready_after[%0d]", k), 64'(req_ready[k]), 64'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen;
      cyc      = 0;
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      for (int k = 0; k < NI; k++) begin
         req_valid[k]   = 1'b0;
         req_write[k]   = 1'b0;
         req_address[k] = '0;
         req_wdata[k]   = '0;
         req_size[k]    = '0;
         resp_ready[k]  = 1'b0;
         have_cur[k]    = 1'b0;
         prev_v[k]      = 1'b0;
      end

      repeat (3) begin
         @(negedge clk);
         for (int k = 0; k < NI; k++) begin
            chk($sformatf("rst_req_ready[%0d]", k), 64'(req_ready[k]), 64'd0);
            chk($sformatf("rst_resp_valid[%0d]", k), 64'(resp_valid[k]), 64'd0);
         end
      end
      rst = 1'b0;
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
         chk($sformatf("post_rst_req_ready[%0d]", k), 64'(req_ready[k]), 64'd1);
         chk($sformatf("post_rst_rdata[%0d]", k), resp_rdata[k], 64'd0);
         chk($sformatf("post_rst_error[%0d]", k), 64'(resp_error[k]), 64'd0);
      end

      // Fill every memory with random data so arbitrary loads have a known answer.
      for (int k = 0; k < NI; k++)
         for (int a = 0; a < DEPTH; a += 8)
            xfer(k, 1'b1, 64'(a), {$urandom, $urandom}, 8, 0, 1'b0, '0, 1'b0);

      // Store/load round trip on each latency variant.
      for (int k = 0; k < NI; k++) begin
         xfer(k, 1'b1, 64'd8, 64'h0123456789ABCDEF, 8, 0, 1'b1, 64'd0, 1'b0);
         xfer(k, 1'b0, 64'd8, 64'd0, 8, 0, 1'b1, 64'h0123456789ABCDEF, 1'b0);
      end

      xfer(0, 1'b0, 64'd8,  64'd0, 2, 0, 1'b1, 64'h0000000000000123, 1'b0);
      xfer(0, 1'b0, 64'd15, 64'd0, 1, 0, 1'b1, 64'h00000000000000EF, 1'b0);
      xfer(0, 1'b0, 64'd12, 64'd0, 4, 0, 1'b1, 64'h0000000089ABCDEF, 1'b0);

      xfer(0, 1'b0, 64'd6,   64'd0, 4, 0, 1'b1, 64'd0, 1'b1);
      xfer(0, 1'b1, 64'd0,   64'hDEAD, 3, 0, 1'b1, 64'd0, 1'b1);
      xfer(0, 1'b0, 64'd128, 64'd0, 1, 0, 1'b1, 64'd0, 1'b1);
      xfer(0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'h55, 8, 0, 1'b1, 64'd0, 1'b1);
      xfer(0, 1'b1, 64'd120, 64'h77, 16, 0, 1'b1, 64'd0, 1'b1);
      xfer(0, 1'b0, 64'd8,   64'd0, 8, 0, 1'b1, 64'h0123456789ABCDEF, 1'b0);

      xfer(0, 1'b0, 64'd8, 64'd0, 8, 3, 1'b1, 64'h0123456789ABCDEF, 1'b0);
      xfer(2, 1'b0, 64'd6, 64'd0, 4, 3, 1'b1, 64'd0, 1'b1);

      // Reset while a store is in flight drops it without a response.
      xfer(0, 1'b1, 64'd16, 64'h1111, 8, 0, 1'b1, 64'd0, 1'b0);
      @(negedge clk);
      req_valid[0]   = 1'b1;
      req_write[0]   = 1'b1;
      req_address[0] = 64'd16;
      req_wdata[0]   = 64'hFFFF;
      req_size[0]    = 4'd8;
      @(posedge clk);
      #1;
      req_valid[0] = 1'b0;
      @(negedge clk);
      rst  = 1'b1;
      seen = 0;
      repeat (2) begin
         @(negedge clk);
         chk("drop_rst_req_ready", 64'(req_ready[0]), 64'd0);
         seen += int'(resp_valid[0]);
      end
      rst = 1'b0;
      repeat (6) begin
         @(negedge clk);
         seen += int'(resp_valid[0]);
      end
      chk("drop_no_resp", 64'(seen), 64'd0);
      xfer(0, 1'b0, 64'd16, 64'd0, 8, 0, 1'b1, 64'h0000000000001111, 1'b0);

      for (int t = 0; t < 90; t++) begin
         int          k;
         int          s;
         int          hold;
         bit          w;
         logic [63:0] a;
         k    = int'($urandom_range(0, NI - 1));
         w    = 1'($urandom_range(0, 1));
         hold = int'($urandom_range(0, 2));
         case ($urandom_range(0, 9))
            0:       s = 3;
            1:       s = int'($urandom_range(0, 15));
            default: s = 1 << $urandom_range(0, 3);
         endcase
         a = 64'($urandom_range(0, DEPTH - 1));
         if ($urandom_range(0, 4) == 0) a = 64'($urandom_range(0, DEPTH + 12));
         else if (s > 0) a = a - (a % 64'(s));
         xfer(k, w, a, {$urandom, $urandom}, s, hold, 1'b0, '0, 1'b0);
      end

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
